// File: rtl/mc_main_fsm.sv
// Multicycle RV32 main controller: Moore sequencing FSM plus ALU/branch decode.
// Optional illegal-instruction trap state enabled by defining MC_FSM_ILLEGAL_TRAP_EN.
module mc_main_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        negative,
   input  logic        carry,
   input  logic        overflow,
   output logic        pcwrite,
   output logic        AddrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic [1:0]  ResultSrc,
   output logic [3:0]  state,
   output logic        illegal
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10
`ifdef MC_FSM_ILLEGAL_TRAP_EN
      ,TRAP    = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [2:0] alu_dec;
   logic       taken;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7b5 = instr[30];
   assign state    = state_q;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= state_t'(RESET_STATE);
      else        state_q <= state_d;
   end

   always_comb begin
      alu_dec = ALU_ADD;
      case (funct3)
         3'b000:  alu_dec = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b100:  alu_dec = ALU_XOR;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_dec = ALU_ADD;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = !(negative ^ overflow);
         3'b110:  taken = !carry;
         3'b111:  taken = carry;
         default: taken = 1'b0;
      endcase
   end

`ifdef MC_FSM_ILLEGAL_TRAP_EN
   logic f3_bad;
   assign f3_bad  = (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);
   assign illegal = (state_q == TRAP);
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_d    = FETCH;
      pcwrite    = 1'b0;
      AddrSrc    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'd0;
      ALUSrcB    = 2'd0;
      ImmSrc     = 2'd0;
      ALUControl = ALU_ADD;
      ResultSrc  = 2'd0;
      case (state_q)
         FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'd2;
            ResultSrc = 2'd2;
            pcwrite   = 1'b1;
            state_d   = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd1;
            ImmSrc  = (opcode == OP_JAL) ? 2'd3 : 2'd2;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_R:              state_d = EXECR;
               OP_I:              state_d = EXECI;
               OP_JAL:            state_d = JAL;
               OP_BR:             state_d = BRANCH;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
               default:           state_d = TRAP;
`else
               default:           state_d = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'd2;
            ALUSrcB = 2'd1;
            ImmSrc  = (opcode == OP_STORE) ? 2'd1 : 2'd0;
            state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AddrSrc = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'd1;
            RegWrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AddrSrc  = 1'b1;
            MemWrite = 1'b1;
            state_d  = FETCH;
         end
         EXECR, EXECI: begin
            ALUSrcA    = 2'd2;
            ALUSrcB    = (state_q == EXECI) ? 2'd1 : 2'd0;
            ALUControl = alu_dec;
`ifdef MC_FSM_ILLEGAL_TRAP_EN
            state_d    = f3_bad ? TRAP : ALUWB;
`else
            state_d    = ALUWB;
`endif
         end
         ALUWB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         JAL: begin
            ALUSrcA = 2'd1;
            ALUSrcB = 2'd2;
            pcwrite = 1'b1;
            state_d = ALUWB;
         end
         BRANCH: begin
            ALUSrcA    = 2'd2;
            ALUControl = ALU_SUB;
            pcwrite    = taken;
            state_d    = FETCH;
         end
`ifdef MC_FSM_ILLEGAL_TRAP_EN
         TRAP:    state_d = TRAP;
`endif
         default: state_d = FETCH;
      endcase
      // Reset masks all write enables combinationally so an abandoned instruction cannot commit.
      if (!reset) begin
         pcwrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule
